// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter in front of a single-port synchronous memory, with tagged read return.
// Optional feature: define MEM_ARBITER_PRIO0_EN to give channel 0 fixed highest priority.

module mem_arbiter_lane #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              sel_we,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [DATA_W-1:0] sel_wdata
);
  // Gated per-channel fields; the top ORs all lanes, so only the one-hot winner survives.
  assign sel_we    = sel & we;
  assign sel_addr  = sel ? addr  : '0;
  assign sel_wdata = sel ? wdata : '0;
endmodule

module mem_arbiter #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int LATENCY  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        req,
  input  logic [CHANNELS-1:0]        we,
  input  logic [CHANNELS*ADDR_W-1:0] addr,
  input  logic [CHANNELS*DATA_W-1:0] wdata,
  output logic [CHANNELS-1:0]        gnt,
  output logic [CHANNELS-1:0]        rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_W-1:0]          mem_a,
  output logic [DATA_W-1:0]          mem_d,
  output logic                       mem_w,
  input  logic [DATA_W-1:0]          mem_q
);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef MEM_ARBITER_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [PW-1:0]                     ptr, ptr_nxt, win_id;
  logic [CHANNELS-1:0]               gnt_c;
  logic                              accept;
  logic [CHANNELS-1:0]               lane_we;
  logic [CHANNELS-1:0][ADDR_W-1:0]   lane_addr;
  logic [CHANNELS-1:0][DATA_W-1:0]   lane_wdata;
  logic                              sel_we;
  logic [ADDR_W-1:0]                 sel_addr;
  logic [DATA_W-1:0]                 sel_wdata;
  logic [LATENCY:0]                  vld_pipe;
  logic [LATENCY:0][PW-1:0]          id_pipe;

  generate
    if (CHANNELS == 1) begin : g_single
      always_comb begin
        gnt_c   = req & {CHANNELS{~reset}};
        win_id  = '0;
        ptr_nxt = '0;
      end
    end else begin : g_multi
      always_comb begin : arb
        logic         found;
        logic [PW:0]  idx;
        gnt_c   = '0;
        win_id  = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = '0;
        // Channel 0 bypasses the rotation and leaves ptr alone when prioritised.
        if (PRIO0 && req[0]) begin
          found    = 1'b1;
          gnt_c[0] = 1'b1;
        end
        for (int o = 0; o < CHANNELS; o++) begin
          idx = {1'b0, ptr} + (PW+1)'(o);
          if (idx >= (PW+1)'(CHANNELS)) idx = idx - (PW+1)'(CHANNELS);
          if (!found && req[idx[PW-1:0]] && !(PRIO0 && idx == '0)) begin
            found               = 1'b1;
            gnt_c[idx[PW-1:0]]  = 1'b1;
            win_id              = idx[PW-1:0];
            if (idx[PW-1:0] == PW'(CHANNELS-1)) ptr_nxt = PRIO0 ? PW'(1) : '0;
            else                                ptr_nxt = idx[PW-1:0] + PW'(1);
          end
        end
        if (reset) gnt_c = '0;
      end
    end
  endgenerate

  assign gnt    = gnt_c;
  assign accept = |gnt_c;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      mem_arbiter_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
        .sel       (gnt_c[gi]),
        .we        (we[gi]),
        .addr      (addr[gi*ADDR_W +: ADDR_W]),
        .wdata     (wdata[gi*DATA_W +: DATA_W]),
        .sel_we    (lane_we[gi]),
        .sel_addr  (lane_addr[gi]),
        .sel_wdata (lane_wdata[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_we    = |lane_we;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_addr  = sel_addr  | lane_addr[i];
      sel_wdata = sel_wdata | lane_wdata[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= '0;
      mem_a    <= '0;
      mem_d    <= '0;
      mem_w    <= 1'b0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        ptr   <= ptr_nxt;
        mem_a <= sel_addr;
        mem_d <= sel_wdata;
        mem_w <= sel_we;
      end else begin
        mem_w <= 1'b0;
      end
      // Tail stage LATENCY lines up with mem_q for the read accepted LATENCY+1 edges ago.
      vld_pipe <= {vld_pipe[LATENCY-1:0], accept & ~sel_we};
      id_pipe  <= {id_pipe[LATENCY-1:0], win_id};
      rdata    <= mem_q;
      rvalid   <= '0;
      if (vld_pipe[LATENCY]) rvalid[id_pipe[LATENCY]] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 3-channel/latency-2 instance with a memory model and scoreboard,
// plus a 1-channel/latency-1 instance for the single-channel streaming case.
module tb_mem_arbiter;
  localparam int C = 3, AW = 20, DW = 8, L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [C-1:0]    req, we, gnt, rvalid;
  logic [C*AW-1:0] addr;
  logic [C*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_d, mem_q;
  logic [AW-1:0]   mem_a;
  logic            mem_w;

  mem_arbiter #(.CHANNELS(C), .ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) u_dut (
    .clock(clk), .reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_a(mem_a), .mem_d(mem_d),
    .mem_w(mem_w), .mem_q(mem_q)
  );

  logic          req1, we1, gnt1, rvalid1, mem_w1;
  logic [AW-1:0] addr1, mem_a1;
  logic [DW-1:0] wdata1, rdata1, mem_d1, mem_q1;

  mem_arbiter #(.CHANNELS(1), .ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_one (
    .clock(clk), .reset(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .mem_a(mem_a1), .mem_d(mem_d1),
    .mem_w(mem_w1), .mem_q(mem_q1)
  );

  function automatic logic [7:0] pre(int a);
    return (a == 'h123) ? 8'hA5 : (8'(a) ^ 8'h5A);
  endfunction

  // Memory model: preloaded while in reset, read latency L.
  logic [7:0] mem [4096];
  logic [7:0] q_pipe [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pre(i);
    end else if (mem_w) begin
      mem[mem_a[11:0]] <= mem_d;
    end
    q_pipe[0] <= mem[mem_a[11:0]];
    for (int j = 1; j < L; j++) q_pipe[j] <= q_pipe[j-1];
  end
  assign mem_q = q_pipe[L-1];

  always @(posedge clk) mem_q1 <= mem_a1[7:0] ^ 8'hC3;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0, failures = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  typedef struct { int id; logic [7:0] data; int due; } exp_t;
  exp_t sb[$];
  logic [7:0] shadow [4096];

  always @(negedge clk) begin : mon
    exp_t e;
    logic [C-1:0] one;
    one = 1;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due < cyc_cnt) begin
        e = sb.pop_front();
        chk("missing_rvalid", 64'(cyc_cnt), 64'(e.due));
      end
      if (rvalid != '0) begin
        if (sb.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("rvalid_id", 64'(rvalid), 64'(one << e.id));
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("read_latency", 64'(cyc_cnt), 64'(e.due));
        end
      end
    end
  end

  // One cycle: present r/w with given buses, check grant, score the expected winner.
  task automatic drive(logic [C-1:0] r, logic [C-1:0] w, logic [C*AW-1:0] a,
                       logic [C*DW-1:0] d, logic [C-1:0] eg, string nm);
    logic [AW-1:0] ka;
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d;
    #1;
    chk(nm, 64'(gnt), 64'(eg));
    for (int k = 0; k < C; k++) begin
      if (eg[k]) begin
        ka = a[k*AW +: AW];
        if (w[k]) shadow[ka[11:0]] = d[k*DW +: DW];
        else sb.push_back('{k, shadow[ka[11:0]], cyc_cnt + L + 2});
      end
    end
    @(posedge clk);
    #1;
    req = '0; we = '0;
  endtask

  typedef struct { logic [2:0] req; logic [2:0] gnt; } vec_t;
  vec_t tab [18];
  logic [C*AW-1:0] abus;

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
`ifdef MEM_ARBITER_PRIO0_EN
    tab = '{'{3'b111,3'b001}, '{3'b111,3'b001}, '{3'b111,3'b001}, '{3'b111,3'b001},
            '{3'b111,3'b001}, '{3'b111,3'b001}, '{3'b110,3'b010}, '{3'b110,3'b100},
            '{3'b110,3'b010}, '{3'b101,3'b001}, '{3'b100,3'b100}, '{3'b100,3'b100},
            '{3'b000,3'b000}, '{3'b011,3'b001}, '{3'b011,3'b001}, '{3'b010,3'b010},
            '{3'b001,3'b001}, '{3'b110,3'b100}};
`else
    tab = '{'{3'b111,3'b001}, '{3'b111,3'b010}, '{3'b111,3'b100}, '{3'b111,3'b001},
            '{3'b111,3'b010}, '{3'b111,3'b100}, '{3'b110,3'b010}, '{3'b110,3'b100},
            '{3'b110,3'b010}, '{3'b101,3'b100}, '{3'b100,3'b100}, '{3'b100,3'b100},
            '{3'b000,3'b000}, '{3'b011,3'b001}, '{3'b011,3'b010}, '{3'b010,3'b010},
            '{3'b001,3'b001}, '{3'b110,3'b010}};
`endif
    for (int i = 0; i < 4096; i++) shadow[i] = pre(i);

    // Reset state, including grant suppression while reset is high.
    repeat (2) @(negedge clk);
    req = '1; req1 = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_mem_a", 64'(mem_a), 64'd0);
    chk("rst_mem_d", 64'(mem_d), 64'd0);
    chk("rst_mem_w", 64'(mem_w), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_one_out", 64'({rvalid1, rdata1, mem_w1, mem_d1, mem_a1}), 64'd0);
    req = '0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Arbitration table; all reads, scored through the read pipeline.
    for (int v = 0; v < 18; v++) begin
      for (int i = 0; i < C; i++) abus[i*AW +: AW] = AW'('h100 + v*4 + i);
      drive(tab[v].req, 3'b000, abus, '0, tab[v].gnt, $sformatf("gnt_vec%0d", v));
    end
    repeat (6) drive('0, '0, '0, '0, '0, "gnt_idle");

    // Single read of the preloaded location; address registered one cycle later.
    abus = '0; abus[1*AW +: AW] = 20'h00123;
    drive(3'b010, 3'b000, abus, '0, 3'b010, "gnt_rd123");
    @(negedge clk); #1;
    chk("mem_a_rd123", 64'(mem_a), 64'h123);
    chk("mem_w_rd123", 64'(mem_w), 64'd0);
    repeat (6) drive('0, '0, '0, '0, '0, "gnt_idle");

    // Write by channel 0 then read-back by channel 1 on the next cycle.
    abus = '0; abus[0 +: AW] = 20'h00400;
    drive(3'b001, 3'b001, abus, {16'h0, 8'h5A}, 3'b001, "gnt_wr400");
    @(negedge clk);
    abus = '0; abus[1*AW +: AW] = 20'h00400;
    req = 3'b010; we = '0; addr = abus;
    #1;
    chk("gnt_rd400", 64'(gnt), 64'b010);
    chk("mem_w_pulse", 64'(mem_w), 64'd1);
    chk("mem_a_wr", 64'(mem_a), 64'h400);
    chk("mem_d_wr", 64'(mem_d), 64'h5A);
    sb.push_back('{1, shadow[12'h400], cyc_cnt + L + 2});
    @(posedge clk); #1;
    req = '0;
    @(negedge clk); #1;
    chk("mem_w_drop", 64'(mem_w), 64'd0);
    chk("mem_a_rd400", 64'(mem_a), 64'h400);
    repeat (6) drive('0, '0, '0, '0, '0, "gnt_idle");

    // Read in flight when reset hits must never come back.
    abus = '0; abus[2*AW +: AW] = 20'h00130;
    drive(3'b100, 3'b000, abus, '0, 3'b100, "gnt_pre_rst");
    @(negedge clk);
    rst = 1'b1; req = 3'b111;
    #1;
    chk("gnt_in_rst", 64'(gnt), 64'd0);
    sb.delete();
    for (int i = 0; i < 4096; i++) shadow[i] = pre(i);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out", 64'({rvalid, rdata, mem_w, mem_d}), 64'd0);
    chk("post_rst_mem_a", 64'(mem_a), 64'd0);
    repeat (8) drive('0, '0, '0, '0, '0, "gnt_idle");

    // Single channel: eight back-to-back reads stream out in order three cycles later.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req1 = (i < 8); addr1 = AW'(i);
      #1;
      chk($sformatf("gnt1_%0d", i), 64'(gnt1), 64'(i < 8));
      if (i >= 3 && i < 11) begin
        chk($sformatf("rvalid1_%0d", i), 64'(rvalid1), 64'd1);
        chk($sformatf("rdata1_%0d", i), 64'(rdata1), 64'(8'(i-3) ^ 8'hC3));
      end else begin
        chk($sformatf("rvalid1_%0d", i), 64'(rvalid1), 64'd0);
      end
    end
    req1 = 1'b0;

    repeat (6) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end
endmodule
